// File: rtl/ram_arbiter.sv
// Single-port BRAM arbiter: Z80 CPU with fixed priority, secondary master via req/ack,
// with a starvation counter that forces one secondary slot and stalls the CPU.
module ram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_rd,
    input  logic                  cpu_wr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_wait_n,
    input  logic                  sec_req,
    input  logic                  sec_we,
    input  logic [ADDR_WIDTH-1:0] sec_addr,
    input  logic [DATA_WIDTH-1:0] sec_wdata,
    output logic                  sec_ack,
    output logic [DATA_WIDTH-1:0] sec_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic {IDLE, SEC_RESP} state_t;

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  forced_q, forced_d;
    logic                  sec_rd_q, sec_rd_d;
    logic                  cpu_rd_prev_q, cpu_rd_prev_d;
    logic [DATA_WIDTH-1:0] cpu_shadow_q, cpu_shadow_d;
    logic [DATA_WIDTH-1:0] sec_rdata_q, sec_rdata_d;

    logic cpu_req;
    logic forced;
    logic gnt_sec;
    logic gnt_cpu;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            forced_q      <= 1'b0;
            sec_rd_q      <= 1'b0;
            cpu_rd_prev_q <= 1'b0;
            cpu_shadow_q  <= '0;
            sec_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            forced_q      <= forced_d;
            sec_rd_q      <= sec_rd_d;
            cpu_rd_prev_q <= cpu_rd_prev_d;
            cpu_shadow_q  <= cpu_shadow_d;
            sec_rdata_q   <= sec_rdata_d;
        end
    end

    // Grant decision and next state; forced slot overrides the CPU only from IDLE.
    always_comb begin
        cpu_req = cpu_rd | cpu_wr;
        forced  = (STARVE_LIMIT != 0) && (state_q == IDLE) && sec_req && (cnt_q == LIMIT);
        gnt_sec = forced || (!cpu_req && sec_req && (state_q == IDLE));
        gnt_cpu = cpu_req && !forced;

        state_d       = gnt_sec ? SEC_RESP : IDLE;
        forced_d      = forced;
        sec_rd_d      = gnt_sec && !sec_we;
        cpu_rd_prev_d = gnt_cpu && !cpu_wr;
        cpu_shadow_d  = cpu_rdata;
        sec_rdata_d   = sec_rdata;

        cnt_d = cnt_q;
        if (gnt_sec || !sec_req) begin
            cnt_d = '0;
        end else if ((state_q == IDLE) && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        ram_addr  = cpu_addr;
        ram_we    = gnt_cpu && cpu_wr;
        ram_wdata = cpu_wdata;
        if (gnt_sec) begin
            ram_addr  = sec_addr;
            ram_we    = sec_we;
            ram_wdata = sec_wdata;
        end

        // Read data bypasses straight from the BRAM in the cycle after a granted read.
        cpu_rdata  = cpu_rd_prev_q ? ram_rdata : cpu_shadow_q;
        sec_ack    = (state_q == SEC_RESP);
        sec_rdata  = (sec_ack && sec_rd_q) ? ram_rdata : sec_rdata_q;
        cpu_wait_n = !(forced || (sec_ack && forced_q));
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table plus hand sequences for starvation,
// disabled forcing and reset mid-transaction.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_wdata;
    logic        sec_req, sec_req0, sec_we;
    logic [15:0] sec_addr;
    logic [7:0]  sec_wdata;
    logic        preload;

    logic [7:0]  cpu_rdata, sec_rdata, ram_wdata, ram_rdata;
    logic        cpu_wait_n, sec_ack, ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  cpu_rdata0, sec_rdata0, ram_wdata0, ram_rdata0;
    logic        cpu_wait_n0, sec_ack0, ram_we0;
    logic [15:0] ram_addr0;

    logic [7:0] mem16 [0:65535];
    logic [7:0] mem0  [0:65535];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .STARVE_LIMIT(16)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n),
        .sec_req(sec_req), .sec_we(sec_we), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
        .sec_ack(sec_ack), .sec_rdata(sec_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .STARVE_LIMIT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata0), .cpu_wait_n(cpu_wait_n0),
        .sec_req(sec_req0), .sec_we(sec_we), .sec_addr(sec_addr), .sec_wdata(sec_wdata),
        .sec_ack(sec_ack0), .sec_rdata(sec_rdata0),
        .ram_addr(ram_addr0), .ram_we(ram_we0), .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
    );

    // BRAM models: 1-cycle registered read, read-before-write
    always @(posedge clk) begin
        if (preload) begin
            mem16[16'h1234] <= 8'hA5;
            mem0[16'h1234]  <= 8'hA5;
        end else begin
            if (ram_we)  mem16[ram_addr]  <= ram_wdata;
            if (ram_we0) mem0[ram_addr0]  <= ram_wdata0;
        end
        ram_rdata  <= mem16[ram_addr];
        ram_rdata0 <= mem0[ram_addr0];
    end

    typedef struct {
        logic        rd, wr;
        logic [15:0] caddr;
        logic [7:0]  cwd;
        logic        sreq, swe;
        logic [15:0] saddr;
        logic [7:0]  swd;
        logic [15:0] e_addr;
        logic        e_we, e_ack;
        logic [7:0]  e_crd, e_srd;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] caddr,
                         input logic [7:0] cwd, input logic sreq, input logic swe,
                         input logic [15:0] saddr, input logic [7:0] swd);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = caddr; cpu_wdata = cwd;
        sec_req = sreq; sec_we = swe; sec_addr = saddr; sec_wdata = swd;
    endtask

    int wait_lows;

    initial begin
        //            rd wr caddr     cwd    sreq swe saddr     swd     e_addr  we ack crd    srd
        vecs[0]  = '{0, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, 16'h1234, 0, 0, 8'h00, 8'h00};
        vecs[1]  = '{1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, 16'h1234, 0, 0, 8'h00, 8'h00};
        vecs[2]  = '{0, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, 16'h1234, 0, 0, 8'hA5, 8'h00};
        vecs[3]  = '{0, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, 16'h1234, 0, 0, 8'hA5, 8'h00};
        vecs[4]  = '{0, 0, 16'h1234, 8'h00, 1, 1, 16'h8000, 8'h5A, 16'h8000, 1, 0, 8'hA5, 8'h00};
        vecs[5]  = '{0, 0, 16'h1234, 8'h00, 1, 1, 16'h8000, 8'h5A, 16'h1234, 0, 1, 8'hA5, 8'h00};
        vecs[6]  = '{0, 0, 16'h1234, 8'h00, 1, 0, 16'h8000, 8'h00, 16'h8000, 0, 0, 8'hA5, 8'h00};
        vecs[7]  = '{0, 0, 16'h1234, 8'h00, 1, 0, 16'h8000, 8'h00, 16'h1234, 0, 1, 8'hA5, 8'h5A};
        vecs[8]  = '{0, 0, 16'h1234, 8'h00, 0, 0, 16'h8000, 8'h00, 16'h1234, 0, 0, 8'hA5, 8'h5A};
        vecs[9]  = '{0, 0, 16'h1234, 8'h00, 1, 1, 16'h2800, 8'h77, 16'h2800, 1, 0, 8'hA5, 8'h5A};
        vecs[10] = '{1, 0, 16'h2800, 8'h00, 1, 1, 16'h2800, 8'h77, 16'h2800, 0, 1, 8'hA5, 8'h5A};
        vecs[11] = '{0, 0, 16'h2800, 8'h00, 0, 0, 16'h0000, 8'h00, 16'h2800, 0, 0, 8'h77, 8'h5A};
        vecs[12] = '{0, 1, 16'h3000, 8'h33, 0, 0, 16'h0000, 8'h00, 16'h3000, 1, 0, 8'h77, 8'h5A};
        vecs[13] = '{0, 0, 16'h3000, 8'h00, 1, 0, 16'h3000, 8'h00, 16'h3000, 0, 0, 8'h77, 8'h5A};
        vecs[14] = '{0, 0, 16'h3000, 8'h00, 1, 0, 16'h3000, 8'h00, 16'h3000, 0, 1, 8'h77, 8'h33};
        vecs[15] = '{0, 0, 16'h3000, 8'h00, 0, 0, 16'h0000, 8'h00, 16'h3000, 0, 0, 8'h77, 8'h33};
        vecs[16] = '{1, 1, 16'h4000, 8'hC3, 0, 0, 16'h0000, 8'h00, 16'h4000, 1, 0, 8'h77, 8'h33};
        vecs[17] = '{1, 0, 16'h4000, 8'h00, 0, 0, 16'h0000, 8'h00, 16'h4000, 0, 0, 8'h77, 8'h33};
        vecs[18] = '{0, 0, 16'h4000, 8'h00, 0, 0, 16'h0000, 8'h00, 16'h4000, 0, 0, 8'hC3, 8'h33};
        vecs[19] = '{1, 0, 16'h8000, 8'h00, 1, 1, 16'h8000, 8'h11, 16'h8000, 0, 0, 8'hC3, 8'h33};
        vecs[20] = '{0, 0, 16'h8000, 8'h00, 1, 1, 16'h8000, 8'h11, 16'h8000, 1, 0, 8'h5A, 8'h33};
        vecs[21] = '{0, 0, 16'h8000, 8'h00, 1, 1, 16'h8000, 8'h11, 16'h8000, 0, 1, 8'h5A, 8'h33};
        vecs[22] = '{0, 0, 16'h8000, 8'h00, 0, 0, 16'h0000, 8'h00, 16'h8000, 0, 0, 8'h5A, 8'h33};

        // Reset values
        reset_n = 1'b0; preload = 1'b1; sec_req0 = 1'b0;
        drive(0, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00);
        repeat (2) @(negedge clk);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_sec_ack", sec_ack, 1'b0);
        chk("rst_sec_rdata", sec_rdata, 8'h00);
        chk("rst_wait_n", cpu_wait_n, 1'b1);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 16'h1234);
        preload = 1'b0;
        reset_n = 1'b1;

        // Vector table, one row per clock
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vecs[i].rd, vecs[i].wr, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].sreq, vecs[i].swe, vecs[i].saddr, vecs[i].swd);
            sec_req0 = vecs[i].sreq;
            #1;
            chk($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
            chk($sformatf("v%0d_sec_ack", i), sec_ack, vecs[i].e_ack);
            chk($sformatf("v%0d_wait_n", i), cpu_wait_n, 1'b1);
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_crd);
            chk($sformatf("v%0d_sec_rdata", i), sec_rdata, vecs[i].e_srd);
        end

        // Starvation: CPU reads 0x1234 continuously, forced slot on cycle 17
        @(negedge clk);
        drive(1, 0, 16'h1234, 8'h00, 0, 0, 16'h8000, 8'h00);
        sec_req0 = 1'b0;
        wait_lows = 0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            sec_req = (k <= 18);
            #1;
            if (!cpu_wait_n) wait_lows++;
            chk($sformatf("st%0d_ram_addr", k), ram_addr, (k == 17) ? 16'h8000 : 16'h1234);
            chk($sformatf("st%0d_wait_n", k), cpu_wait_n, (k == 17 || k == 18) ? 1'b0 : 1'b1);
            chk($sformatf("st%0d_sec_ack", k), sec_ack, (k == 18) ? 1'b1 : 1'b0);
            chk($sformatf("st%0d_cpu_rdata", k), cpu_rdata, 8'hA5);
            if (k == 18) chk("st_sec_rdata", sec_rdata, 8'h11);
        end
        chk("st_wait_low_cycles", wait_lows, 2);

        // Forcing disabled: secondary waits until the CPU lets go
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            drive(1, 0, 16'h1234, 8'h00, 0, 0, 16'h8000, 8'h00);
            sec_req0 = 1'b1;
            #1;
            chk($sformatf("s0_%0d_ack", j), sec_ack0, 1'b0);
            chk($sformatf("s0_%0d_addr", j), ram_addr0, 16'h1234);
        end
        @(negedge clk);
        cpu_rd = 1'b0;
        #1;
        chk("s0_grant_addr", ram_addr0, 16'h8000);
        chk("s0_grant_ack", sec_ack0, 1'b0);
        @(negedge clk);
        #1;
        chk("s0_ack", sec_ack0, 1'b1);
        chk("s0_rdata", sec_rdata0, 8'h11);
        chk("s0_wait_n", cpu_wait_n0, 1'b1);
        @(negedge clk);
        sec_req0 = 1'b0;

        // Reset asserted in a secondary grant cycle
        @(negedge clk);
        drive(0, 0, 16'h1234, 8'h00, 1, 1, 16'h9000, 8'hEE);
        #1;
        chk("rm_grant_addr", ram_addr, 16'h9000);
        chk("rm_grant_we", ram_we, 1'b1);
        #1;
        reset_n = 1'b0;
        sec_req = 1'b0;
        #1;
        chk("rm_ram_we", ram_we, 1'b0);
        @(negedge clk);
        chk("rm_sec_ack", sec_ack, 1'b0);
        chk("rm_wait_n", cpu_wait_n, 1'b1);
        chk("rm_cpu_rdata", cpu_rdata, 8'h00);
        chk("rm_sec_rdata", sec_rdata, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rm_idle_ack", sec_ack, 1'b0);
        @(negedge clk);
        drive(0, 0, 16'h1234, 8'h00, 1, 0, 16'h8000, 8'h00);
        #1;
        chk("rm_new_addr", ram_addr, 16'h8000);
        @(negedge clk);
        #1;
        chk("rm_new_ack", sec_ack, 1'b1);
        chk("rm_new_rdata", sec_rdata, 8'h11);
        @(negedge clk);
        sec_req = 1'b0;
        #1;
        chk("rm_new_ack_done", sec_ack, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single port of the 64K BRAM between two requesters.
- Requester one is the Z80 CPU, after address decode. Requester two is a secondary master, such as a serial loader or DMA, using a req/ack handshake.
- The CPU has fixed priority. A starvation counter forces one secondary slot and stalls the CPU through cpu_wait_n.
- The block holds the CPU read data, so secondary accesses never corrupt what the CPU samples.

Parameters:
ADDR_WIDTH, 16, RAM address width
DATA_WIDTH, 8, RAM data width
STARVE_LIMIT, 16, cycles a pending secondary request may wait before a forced grant; 0 disables forcing

Ports:
clk  input  1  system clock (25 MHz), all logic on rising edge
reset_n  input  1  asynchronous active-low reset
cpu_addr  input  ADDR_WIDTH  CPU address
cpu_rd  input  1  CPU RAM read request, level (decoded rd_ram)
cpu_wr  input  1  CPU RAM write request, level (decoded wr_ram)
cpu_wdata  input  DATA_WIDTH  CPU write data
cpu_rdata  output  DATA_WIDTH  CPU read data, held between CPU reads
cpu_wait_n  output  1  low = CPU must stall (to tv80 wait_n)
sec_req  input  1  secondary request, held high until sec_ack
sec_we  input  1  secondary write (1) / read (0), stable while sec_req
sec_addr  input  ADDR_WIDTH  secondary address, stable while sec_req
sec_wdata  input  DATA_WIDTH  secondary write data, stable while sec_req
sec_ack  output  1  one-cycle pulse: secondary access done
sec_rdata  output  DATA_WIDTH  secondary read data, valid in the sec_ack cycle
ram_addr  output  ADDR_WIDTH  to BRAM addr_a
ram_we  output  1  to BRAM we_a
ram_wdata  output  DATA_WIDTH  to BRAM data_in_a
ram_rdata  input  DATA_WIDTH  from BRAM data_out_a, 1-cycle registered read latency

Behaviour:
- Reset values:
  - cpu_rdata = 0, sec_ack = 0, sec_rdata = 0, cpu_wait_n = 1.
  - ram_we = 0. ram_addr follows cpu_addr.
  - State IDLE, starvation counter 0.
- The grant decision is combinational, each cycle. The port mux (ram_addr, ram_we, ram_wdata) is combinational from the grant.
- Grant priority, first match wins:
  1. Forced secondary: state IDLE, sec_req = 1, and the counter equals STARVE_LIMIT (STARVE_LIMIT ≠ 0).
  2. CPU: cpu_rd or cpu_wr is high.
  3. Secondary: sec_req = 1 and state IDLE.
  4. None: ram_we = 0, address = cpu_addr.
- States:
  - IDLE: secondary grant allowed.
  - SEC_RESP: the cycle after a secondary grant. sec_ack = 1 and sec_rdata = ram_rdata (read) or unchanged (write). Secondary grant is blocked here, because sec_req is still high from the same transaction. CPU grant is allowed. Return to IDLE.
  - Transition: any secondary grant → SEC_RESP on the next cycle.
- CPU write: ram_we = cpu_wr in every CPU-granted cycle. Repeated identical writes over a multi-cycle level request are allowed.
- CPU read data:
  - If the previous cycle was a CPU-granted read, cpu_rdata = ram_rdata (combinational bypass), and a shadow register captures it.
  - Otherwise cpu_rdata = the shadow register.
- Simultaneous cpu_rd and cpu_wr: treat as a write.
- Starvation counter:
  - Increments each cycle that sec_req = 1, state is IDLE, and the secondary is not granted. Saturates at STARVE_LIMIT.
  - Clears on any secondary grant or when sec_req = 0.
- cpu_wait_n:
  - Low in the forced-grant cycle and the following cycle (SEC_RESP). High otherwise.
  - After the forced slot, a still-asserted CPU request is re-granted, and cpu_rdata refreshes one cycle later.
- Same address, same cycle: CPU wins unless forced. There is no merging; the secondary sees RAM contents as of its own slot.
- Reset asserted mid-transaction: sec_ack is not emitted, everything returns to reset values, and the master must re-request.
- sec_req dropped without ack is a protocol violation. The arbiter must still not lock up: the counter clears, and if already granted the pulse still occurs.

Test Plan:
- CPU only: cpu_rd at 0x1234 holding 0xA5 → cpu_rdata = 0xA5 one cycle after grant, held after cpu_rd drops; cpu_wait_n stays 1.
- Secondary only, idle CPU: write 0x5A to 0x8000, then read 0x8000 → sec_ack one cycle after each grant, read sec_rdata = 0x5A, no double grant while sec_req remains high in the ack cycle.
- Contention: cpu_rd held continuously with sec_req raised, STARVE_LIMIT = 16 → forced grant on cycle 17 after sec_req rise, cpu_wait_n low for exactly 2 cycles, CPU-held cpu_rdata unchanged during the slot.
- STARVE_LIMIT = 0 with CPU held continuously → sec_ack never asserts. After cpu_rd drops → secondary granted the next cycle, ack the cycle after.
- Interleave: CPU read 0x2800 preceded by a secondary write 0x77 to 0x2800 → CPU reads 0x77. Secondary read after CPU write 0x33 → sec_rdata = 0x33.
- Reset mid-operation: reset_n pulsed low in the grant cycle → no sec_ack, cpu_wait_n = 1, counter 0. A new request after reset completes normally.
